// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

  // Fetch FSM: one idle cycle after reset release, then continuous fetch.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  // Which ID-stage instruction is steering the fetch PC this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_J    = 2'd2,
    SRC_JR   = 2'd3
  } redir_src_e;

  localparam int unsigned      DEF_WIDTH        = 32;
  localparam int unsigned      DEF_INC          = 4;
  localparam logic [31:0]      DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0]      DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch/redirect bundle between pc_unit, hazard unit, decode and imem.
// Latency: n/a (wiring only); exception signals exist only with PC_EPC_EN.
// Backpressure: imem_ready qualifies imem_req; stall holds IF and ID.
interface pc_unit_if #(
  parameter int WIDTH = 32
);

  logic             stall;
  logic             imem_ready;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             br_taken;
  logic [15:0]      br_offset;
  logic             j_en;
  logic [25:0]      j_index;
  logic             jr_en;
  logic [WIDTH-1:0] jr_target;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_pc_next;
  logic             addr_err;
`ifdef PC_EPC_EN
  logic             exc_req;
  logic             eret;
  logic [WIDTH-1:0] exc_pc;
  logic [WIDTH-1:0] epc;
`endif

  // PC unit side.
  modport master (
`ifdef PC_EPC_EN
    input  exc_req, eret, exc_pc,
    output epc,
`endif
    input  stall, imem_ready, br_taken, br_offset, j_en, j_index, jr_en, jr_target,
    output imem_req, imem_addr, id_valid, id_pc, id_pc_next, addr_err
  );

  // Surrounding pipeline side.
  modport slave (
`ifdef PC_EPC_EN
    output exc_req, eret, exc_pc,
    input  epc,
`endif
    output stall, imem_ready, br_taken, br_offset, j_en, j_index, jr_en, jr_target,
    input  imem_req, imem_addr, id_valid, id_pc, id_pc_next, addr_err
  );

endinterface

// File: rtl/pc_target_gen.sv
// Redirect target generator: branch/jump/register-jump priority mux plus misalignment flag.
// Latency: combinational, 0 cycles.
// Backpressure: none; only meaningful when the ID instruction is valid.
module pc_target_gen
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_id_valid,
  input  logic [WIDTH-1:0] i_id_pc_next,
  input  logic             i_br_taken,
  input  logic [15:0]      i_br_offset,
  input  logic             i_j_en,
  input  logic [25:0]      i_j_index,
  input  logic             i_jr_en,
  input  logic [WIDTH-1:0] i_jr_target,
  output logic             o_redir_vld,
  output logic [WIDTH-1:0] o_target,
  output logic             o_misaligned
);

  redir_src_e       w_src;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_j_tgt;

  // Branch offset is a signed word count relative to the delay-slot-free link address.
  assign w_br_tgt = i_id_pc_next + {{(WIDTH-18){i_br_offset[15]}}, i_br_offset, 2'b00};

  generate
    if (WIDTH > 28) begin : g_j_region
      assign w_j_tgt = {i_id_pc_next[WIDTH-1:28], i_j_index, 2'b00};
    end else begin : g_j_flat
      assign w_j_tgt = {i_j_index, 2'b00};
    end
  endgenerate

  // Pick the redirect source: branch beats jump beats register jump, all gated by a live ID slot.
  always_comb begin
    w_src = SRC_NONE;
    if (i_id_valid) begin
      if (i_br_taken)    w_src = SRC_BR;
      else if (i_j_en)   w_src = SRC_J;
      else if (i_jr_en)  w_src = SRC_JR;
    end
  end

  // Route the selected target and flag a non-word-aligned destination.
  always_comb begin
    o_target = '0;
    case (w_src)
      SRC_BR:  o_target = w_br_tgt;
      SRC_J:   o_target = w_j_tgt;
      SRC_JR:  o_target = i_jr_target;
      default: o_target = '0;
    endcase
    o_redir_vld  = (w_src != SRC_NONE);
    o_misaligned = o_redir_vld && (o_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC and IF/ID PC register; redirects, stall and imem back-pressure (EPC/exceptions with PC_EPC_EN).
// Latency: new PC on imem_addr 1 cycle after the qualifying edge; ID outputs 1 cycle after fetch acceptance.
// Backpressure: imem_ready=0 holds PC and bubbles ID; stall holds PC and ID and defers redirects.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int unsigned       INC          = DEF_INC
`ifdef PC_EPC_EN
  ,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
`endif
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.master  bus
);

  pc_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic             r_id_valid, w_id_valid_nxt;
  logic [WIDTH-1:0] r_id_pc, w_id_pc_nxt;
  logic [WIDTH-1:0] r_id_pc_next, w_id_pc_next_nxt;
  logic             r_addr_err, w_addr_err_nxt;
`ifdef PC_EPC_EN
  logic [WIDTH-1:0] r_epc, w_epc_nxt;
`endif

  logic [WIDTH-1:0] w_pc_inc;
  logic             w_imem_req;
  logic             w_redir_vld;
  logic [WIDTH-1:0] w_target;
  logic             w_misaligned;

  assign w_pc_inc = r_pc + WIDTH'(INC);

  pc_target_gen #(.WIDTH(WIDTH)) u_tgt (
    .i_id_valid   (r_id_valid),
    .i_id_pc_next (r_id_pc_next),
    .i_br_taken   (bus.br_taken),
    .i_br_offset  (bus.br_offset),
    .i_j_en       (bus.j_en),
    .i_j_index    (bus.j_index),
    .i_jr_en      (bus.jr_en),
    .i_jr_target  (bus.jr_target),
    .o_redir_vld  (w_redir_vld),
    .o_target     (w_target),
    .o_misaligned (w_misaligned)
  );

  // FSM state register; reset drops back to BOOT even mid-fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next state, fetch request and next PC/ID contents in priority order.
  always_comb begin
    w_state_nxt      = r_state;
    w_imem_req       = (r_state == ST_RUN);
    w_pc_nxt         = r_pc;
    w_id_valid_nxt   = r_id_valid;
    w_id_pc_nxt      = r_id_pc;
    w_id_pc_next_nxt = r_id_pc_next;
    w_addr_err_nxt   = 1'b0;
`ifdef PC_EPC_EN
    w_epc_nxt        = r_epc;
`endif

    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase

`ifdef PC_EPC_EN
    if (bus.exc_req) begin
      w_epc_nxt      = bus.exc_pc;
      w_pc_nxt       = EXC_VECTOR;
      w_id_valid_nxt = 1'b0;
    end else if (bus.eret) begin
      w_pc_nxt       = r_epc;
      w_id_valid_nxt = 1'b0;
    end else
`endif
    if (!w_imem_req || bus.stall) begin
      // Hold everything; a pending ID redirect must be re-presented later.
    end else if (w_redir_vld) begin
      // Redirect wins over imem_ready: the in-flight request is dropped and ID squashed.
      w_addr_err_nxt = w_misaligned;
      w_id_valid_nxt = 1'b0;
`ifdef PC_EPC_EN
      if (w_misaligned) begin
        w_epc_nxt = r_id_pc;
        w_pc_nxt  = EXC_VECTOR;
      end else begin
        w_pc_nxt  = w_target;
      end
`else
      w_pc_nxt = w_target & ~{{(WIDTH-2){1'b0}}, 2'b11};
`endif
    end else if (!bus.imem_ready) begin
      w_id_valid_nxt = 1'b0;
    end else begin
      w_pc_nxt         = w_pc_inc;
      w_id_valid_nxt   = 1'b1;
      w_id_pc_nxt      = r_pc;
      w_id_pc_next_nxt = w_pc_inc;
    end
  end

  // PC, IF/ID register and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_VECTOR;
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_pc_next <= '0;
      r_addr_err   <= 1'b0;
`ifdef PC_EPC_EN
      r_epc        <= '0;
`endif
    end else begin
      r_pc         <= w_pc_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_pc      <= w_id_pc_nxt;
      r_id_pc_next <= w_id_pc_next_nxt;
      r_addr_err   <= w_addr_err_nxt;
`ifdef PC_EPC_EN
      r_epc        <= w_epc_nxt;
`endif
    end
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.id_valid   = r_id_valid;
  assign bus.id_pc      = r_id_pc;
  assign bus.id_pc_next = r_id_pc_next;
  assign bus.addr_err   = r_addr_err;
`ifdef PC_EPC_EN
  assign bus.epc        = r_epc;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset/boot, sequential fetch, imem back-pressure, redirects, stall, misalignment, wrap.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: imem_ready and stall driven from the stimulus sequence.
module tb_pc_unit;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall      = 1'b0;
    bus.imem_ready = 1'b1;
    bus.br_taken   = 1'b0;
    bus.br_offset  = 16'h0000;
    bus.j_en       = 1'b0;
    bus.j_index    = 26'h0;
    bus.jr_en      = 1'b0;
    bus.jr_target  = 32'h0;
`ifdef PC_EPC_EN
    bus.exc_req    = 1'b0;
    bus.eret       = 1'b0;
    bus.exc_pc     = 32'h0;
`endif

    // Reset held for three cycles.
    repeat (3) tick;
    chk("rst_req",   32'(bus.imem_req),   32'h0);
    chk("rst_addr",  bus.imem_addr,       32'h0);
    chk("rst_idv",   32'(bus.id_valid),   32'h0);
    chk("rst_idpc",  bus.id_pc,           32'h0);
    chk("rst_idpcn", bus.id_pc_next,      32'h0);
    chk("rst_aerr",  32'(bus.addr_err),   32'h0);
`ifdef PC_EPC_EN
    chk("rst_epc",   bus.epc,             32'h0);
`endif

    // BOOT cycle, then sequential fetch 0, 4, 8.
    reset = 1'b1;
    chk("boot_req", 32'(bus.imem_req), 32'h0);
    tick;
    chk("run_req",  32'(bus.imem_req), 32'h1);
    chk("addr_0",   bus.imem_addr,     32'h0);
    tick;
    chk("addr_4",   bus.imem_addr,     32'h4);
    chk("idv_4",    32'(bus.id_valid), 32'h1);
    chk("idpc_0",   bus.id_pc,         32'h0);
    chk("idpcn_4",  bus.id_pc_next,    32'h4);
    tick;
    chk("addr_8",   bus.imem_addr,     32'h8);
    chk("idpc_4",   bus.id_pc,         32'h4);

    // Two cycles of imem back-pressure at PC 8.
    bus.imem_ready = 1'b0;
    tick;
    chk("bp1_addr", bus.imem_addr,     32'h8);
    chk("bp1_idv",  32'(bus.id_valid), 32'h0);
    tick;
    chk("bp2_addr", bus.imem_addr,     32'h8);
    chk("bp2_idv",  32'(bus.id_valid), 32'h0);
    bus.imem_ready = 1'b1;
    tick;
    chk("bp_rel_addr", bus.imem_addr,     32'hC);
    chk("bp_rel_idv",  32'(bus.id_valid), 32'h1);
    chk("bp_rel_idpc", bus.id_pc,         32'h8);
    tick;
    tick;
    chk("pre_br_idpc", bus.id_pc,     32'h10);
    chk("pre_br_addr", bus.imem_addr, 32'h14);

    // Taken branch from 0x10 with offset -2 words: 0x14 - 8 = 0x0C.
    bus.br_taken  = 1'b1;
    bus.br_offset = 16'hFFFE;
    tick;
    chk("br_addr", bus.imem_addr,     32'hC);
    chk("br_idv",  32'(bus.id_valid), 32'h0);
    bus.br_taken = 1'b0;
    tick;
    chk("br_seq_addr", bus.imem_addr,     32'h10);
    chk("br_seq_idpc", bus.id_pc,         32'hC);
    chk("br_seq_idv",  32'(bus.id_valid), 32'h1);

    // Stall hides a taken branch (target 0x10 + 16 = 0x20), also with imem not ready.
    bus.stall     = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_offset = 16'h0004;
    tick;
    chk("stl_addr", bus.imem_addr,     32'h10);
    chk("stl_idpc", bus.id_pc,         32'hC);
    chk("stl_idv",  32'(bus.id_valid), 32'h1);
    bus.imem_ready = 1'b0;
    tick;
    chk("stl_nr_addr", bus.imem_addr,     32'h10);
    chk("stl_nr_idv",  32'(bus.id_valid), 32'h1);
    bus.stall      = 1'b0;
    bus.imem_ready = 1'b1;
    tick;
    chk("stl_br_addr", bus.imem_addr,     32'h20);
    chk("stl_br_idv",  32'(bus.id_valid), 32'h0);
    bus.br_taken = 1'b0;
    tick;
    chk("stl_seq_addr", bus.imem_addr, 32'h24);
    chk("stl_seq_idpc", bus.id_pc,     32'h20);

    // Register jump to 0x1000_0000 with imem not ready (redirect still taken).
    bus.jr_en      = 1'b1;
    bus.jr_target  = 32'h1000_0000;
    bus.imem_ready = 1'b0;
    tick;
    chk("jr_addr", bus.imem_addr, 32'h1000_0000);
    bus.jr_en      = 1'b0;
    bus.imem_ready = 1'b1;
    tick;
    chk("jr_seq_idpcn", bus.id_pc_next, 32'h1000_0004);

    // J and JR together: J wins, target keeps the top nibble of id_pc_next.
    bus.j_en      = 1'b1;
    bus.j_index   = 26'h40;
    bus.jr_en     = 1'b1;
    bus.jr_target = 32'h5555_0000;
    tick;
    chk("j_addr", bus.imem_addr,     32'h1000_0100);
    chk("j_aerr", 32'(bus.addr_err), 32'h0);
    bus.j_en  = 1'b0;
    bus.jr_en = 1'b0;
    tick;
    chk("j_seq_idpc", bus.id_pc, 32'h1000_0100);

    // Misaligned register jump.
    bus.jr_en     = 1'b1;
    bus.jr_target = 32'h0000_0202;
    tick;
    chk("mis_aerr", 32'(bus.addr_err), 32'h1);
`ifdef PC_EPC_EN
    chk("mis_addr", bus.imem_addr, 32'h180);
    chk("mis_epc",  bus.epc,       32'h1000_0100);
`else
    chk("mis_addr", bus.imem_addr, 32'h200);
`endif
    bus.jr_en = 1'b0;
    tick;
    chk("mis_pulse_end", 32'(bus.addr_err), 32'h0);
`ifdef PC_EPC_EN
    bus.eret = 1'b1;
    tick;
    chk("eret_addr", bus.imem_addr,     32'h1000_0100);
    chk("eret_idv",  32'(bus.id_valid), 32'h0);
    // Exception beats both stall and eret.
    bus.stall   = 1'b1;
    bus.exc_req = 1'b1;
    bus.exc_pc  = 32'h0000_1234;
    tick;
    chk("exc_addr", bus.imem_addr, 32'h180);
    chk("exc_epc",  bus.epc,       32'h0000_1234);
    bus.stall   = 1'b0;
    bus.exc_req = 1'b0;
    bus.eret    = 1'b0;
`endif
    tick;
    chk("pre_wrap_idv", 32'(bus.id_valid), 32'h1);

    // Jump to the last word, then wrap to 0; a branch while ID is empty is ignored.
    bus.jr_en     = 1'b1;
    bus.jr_target = 32'hFFFF_FFFC;
    tick;
    chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.jr_en     = 1'b0;
    bus.br_taken  = 1'b1;
    bus.br_offset = 16'h0008;
    tick;
    chk("wrap_addr",  bus.imem_addr,     32'h0);
    chk("wrap_idv",   32'(bus.id_valid), 32'h1);
    chk("wrap_idpc",  bus.id_pc,         32'hFFFF_FFFC);
    chk("wrap_idpcn", bus.id_pc_next,    32'h0);
    bus.br_taken = 1'b0;
    tick;
    chk("post_wrap_addr", bus.imem_addr, 32'h4);

    // Reset in the middle of fetching.
    reset = 1'b0;
    #1;
    chk("mid_rst_addr", bus.imem_addr,     32'h0);
    chk("mid_rst_req",  32'(bus.imem_req), 32'h0);
    chk("mid_rst_idv",  32'(bus.id_valid), 32'h0);
    tick;
    reset = 1'b1;
    chk("reboot_req", 32'(bus.imem_req), 32'h0);
    tick;
    chk("rerun_req",  32'(bus.imem_req), 32'h1);
    chk("rerun_addr", bus.imem_addr,     32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
